cacheline_adapter: RTL and testbench
====================================

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 The block SHALL take parameter s_offset, default 5, giving log2 of the line size in bytes.
REQ-002 The block SHALL take parameter s_line, default 256, giving the line width in bits.
REQ-003 The block SHALL take parameter s_burst, default 64, giving the beat width in bits; number of beats = s_line/s_burst (4).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports SHALL be:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous active-high reset
pmem_address  in  32  line address from the cache datapath
pmem_read  in  1  line-fill request from the cache
pmem_write  in  1  write-back request from the cache
pmem_wdata  in  s_line  line to write back
pmem_rdata  out  s_line  assembled fill line
pmem_resp  out  1  one-cycle completion pulse
burst_address  out  32  line-aligned address to memory
burst_read  out  1  memory burst read request
burst_write  out  1  memory burst write request
burst_wdata  out  s_burst  current write beat
burst_rdata  in  s_burst  current read beat
burst_resp  in  1  memory beat-valid / beat-accepted

Function
REQ-006 The block SHALL implement states IDLE, READ, WRITE, DONE.
REQ-007 In IDLE with pmem_read=1 the block SHALL latch the address and go to READ; read wins if pmem_read and pmem_write are both 1.
REQ-008 In IDLE with pmem_write=1 and pmem_read=0 the block SHALL latch address and pmem_wdata and go to WRITE.
REQ-009 burst_address SHALL equal the latched address with bits [s_offset-1:0] forced to 0, held constant from acceptance until DONE.
REQ-010 burst_read SHALL be 1 exactly while in READ; burst_write SHALL be 1 exactly while in WRITE.
REQ-011 A 2-bit beat counter SHALL reset to 0 on acceptance and increment only in cycles with burst_resp=1 in READ or WRITE.
REQ-012 In READ, each cycle with burst_resp=1 SHALL store burst_rdata into line bits [64*count+63 : 64*count] (beat 0 = bits [63:0]).
REQ-013 In WRITE, burst_wdata SHALL equal latched line bits [64*count+63 : 64*count]; it SHALL be 0 outside WRITE.
REQ-014 Cycles with burst_resp=0 in READ/WRITE SHALL be wait states: no counter change, no data capture, outputs held.
REQ-015 On burst_resp=1 with count=3 the block SHALL go to DONE at the next edge.
REQ-016 In DONE the block SHALL assert pmem_resp for exactly one cycle and return to IDLE.
REQ-017 pmem_rdata SHALL present the complete fill line in DONE and hold it until the next READ captures beat 0.
REQ-018 Minimum latency: request accepted at cycle T, beats at T+1..T+4, pmem_resp at T+5; each memory wait cycle adds one.
REQ-019 burst_resp in IDLE or DONE SHALL be ignored.
REQ-020 pmem_read/pmem_write changes after acceptance SHALL be ignored until return to IDLE.
REQ-021 A new request SHALL be accepted no earlier than the IDLE cycle following DONE; no back-to-back pmem_resp.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, count=0, pmem_rdata=0, latched line/address=0.
REQ-023 During and after reset all outputs SHALL be 0 (pmem_resp, burst_read, burst_write, burst_address, burst_wdata, pmem_rdata).
REQ-024 rst asserted mid-burst SHALL abort the transfer; burst_read/burst_write drop the cycle after the reset edge and no pmem_resp is issued.

Verification
REQ-025 Read, no waits: pmem_read, pmem_address=0x0000_1234, beats 0x11..11/0x22..22/0x33..33/0x44..44 at T+1..T+4 -> burst_address=0x0000_1220, pmem_rdata={0x44..,0x33..,0x22..,0x11..}, pmem_resp only at T+5.
REQ-026 Write, no waits: pmem_write, pmem_wdata={D3,D2,D1,D0} -> burst_wdata D0,D1,D2,D3 on successive resp cycles, burst_write high 4 cycles, pmem_resp at T+5.
REQ-027 Read with waits: burst_resp pattern 1,0,0,1,1,0,1 -> beats captured only on 1s, pmem_resp one cycle after the 7th cycle, line correct.
REQ-028 Simultaneous pmem_read=pmem_write=1 in IDLE -> READ entered, burst_write never asserted.
REQ-029 rst after beat 2 of a write -> burst_write=0 next cycle, no pmem_resp; subsequent read completes normally.
REQ-030 Spurious burst_resp in IDLE, then read -> first captured beat lands in bits [63:0].

Source files
------------

// File: rtl/cacheline_adapter_if.sv
// Cache-side and memory-side signal bundle for the cacheline adapter.
// slave  : the adapter's view (takes line requests, drives burst requests).
// master : the environment's view (cache + memory model).
interface cacheline_adapter_if #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
);
  // cache side
  logic [31:0]        pmem_address;
  logic               pmem_read;
  logic               pmem_write;
  logic [s_line-1:0]  pmem_wdata;
  logic [s_line-1:0]  pmem_rdata;
  logic               pmem_resp;
  // memory side
  logic [31:0]        burst_address;
  logic               burst_read;
  logic               burst_write;
  logic [s_burst-1:0] burst_wdata;
  logic [s_burst-1:0] burst_rdata;
  logic               burst_resp;

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata, burst_rdata, burst_resp,
    output pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
  );

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata, burst_rdata, burst_resp,
    input  pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Cacheline adapter: turns one line read/write from the cache into a burst of
// s_line/s_burst beats on the memory side, assembling or slicing the line.
module cacheline_adapter #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_burst  = 64
) (
  input logic                clk,
  input logic                rst,
  cacheline_adapter_if.slave bus
);

  localparam int BEATS = s_line / s_burst;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [31:0]        r_addr;
  logic [s_line-1:0]  r_wline;
  logic [s_line-1:0]  r_rline;
  logic               r_resp;
  logic               r_bread;
  logic               r_bwrite;
  logic [s_burst-1:0] w_wbeat;

  // FSM: accept a request in IDLE, count beats on burst_resp, pulse resp in DONE.
  // The fill line is written beat-by-beat straight into the output register,
  // so the previous line stays visible until the next read overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wline  <= '0;
      r_rline  <= '0;
      r_resp   <= 1'b0;
      r_bread  <= 1'b0;
      r_bwrite <= 1'b0;
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          // read wins when both requests are raised together
          if (bus.pmem_read) begin
            r_addr  <= bus.pmem_address & ADDR_MASK;
            r_cnt   <= '0;
            r_bread <= 1'b1;
            r_state <= READ;
          end else if (bus.pmem_write) begin
            r_addr   <= bus.pmem_address & ADDR_MASK;
            r_wline  <= bus.pmem_wdata;
            r_cnt    <= '0;
            r_bwrite <= 1'b1;
            r_state  <= WRITE;
          end
        end
        READ: begin
          if (bus.burst_resp) begin
            r_rline[r_cnt*s_burst +: s_burst] <= bus.burst_rdata;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_bread <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        WRITE: begin
          if (bus.burst_resp) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_bwrite <= 1'b0;
              r_resp   <= 1'b1;
              r_state  <= DONE;
            end
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_wbeat = r_wline[r_cnt*s_burst +: s_burst];

  assign bus.pmem_rdata    = r_rline;
  assign bus.pmem_resp     = r_resp;
  assign bus.burst_address = r_addr;
  assign bus.burst_read    = r_bread;
  assign bus.burst_write   = r_bwrite;
  assign bus.burst_wdata   = r_bwrite ? w_wbeat : '0;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: reset, reads, writes, wait states,
// read/write priority, mid-burst reset and stray burst_resp in IDLE.
module tb_cacheline_adapter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec  = 0;
  int   miss = 0;

  always #5 clk = ~clk;

  cacheline_adapter_if #(.s_line(256), .s_burst(64)) bus ();

  cacheline_adapter #(.s_offset(5), .s_line(256), .s_burst(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // inputs are changed 1 time unit after an edge, outputs checked there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] B0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B3 = 64'h4444_4444_4444_4444;
  localparam logic [255:0] LINE_A = {B3, B2, B1, B0};
  localparam logic [255:0] LINE_B = {64'hDDDD_0003_DDDD_0003, 64'hCCCC_0002_CCCC_0002,
                                     64'hBBBB_0001_BBBB_0001, 64'hAAAA_0000_AAAA_0000};

  // Zero-wait read; drives the four beats of ln and checks the whole transaction.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_baddr,
                         input logic [255:0] ln, input string tag);
    logic [255:0] l;
    l = ln;
    bus.pmem_read = 1'b1; bus.pmem_address = addr;
    tick();
    bus.pmem_read = 1'b0; bus.pmem_address = 32'hFFFF_FFFF;
    vec++; if (bus.burst_read !== 1'b1) begin miss++;
      $display("FAIL %s.burst_read got %b want 1", tag, bus.burst_read); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (bus.burst_address !== exp_baddr) begin miss++;
        $display("FAIL %s.burst_address[%0d] got %h want %h", tag, i, bus.burst_address, exp_baddr); end
      vec++; if (bus.pmem_resp !== 1'b0) begin miss++;
        $display("FAIL %s.early_resp[%0d] got %b want 0", tag, i, bus.pmem_resp); end
      bus.burst_resp = 1'b1; bus.burst_rdata = l[i*64 +: 64];
      tick();
    end
    bus.burst_resp = 1'b0; bus.burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    vec++; if (bus.pmem_resp !== 1'b1) begin miss++;
      $display("FAIL %s.resp got %b want 1", tag, bus.pmem_resp); end
    vec++; if (bus.pmem_rdata !== ln) begin miss++;
      $display("FAIL %s.rdata got %h want %h", tag, bus.pmem_rdata, ln); end
    vec++; if (bus.burst_read !== 1'b0) begin miss++;
      $display("FAIL %s.burst_read_done got %b want 0", tag, bus.burst_read); end
    tick();
    vec++; if (bus.pmem_resp !== 1'b0) begin miss++;
      $display("FAIL %s.resp_pulse got %b want 0", tag, bus.pmem_resp); end
    vec++; if (bus.pmem_rdata !== ln) begin miss++;
      $display("FAIL %s.rdata_hold got %h want %h", tag, bus.pmem_rdata, ln); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vec++; if (bus.pmem_resp !== 1'b0) begin miss++; $display("FAIL reset.pmem_resp got %b want 0", bus.pmem_resp); end
    vec++; if (bus.burst_read !== 1'b0) begin miss++; $display("FAIL reset.burst_read got %b want 0", bus.burst_read); end
    vec++; if (bus.burst_write !== 1'b0) begin miss++; $display("FAIL reset.burst_write got %b want 0", bus.burst_write); end
    vec++; if (bus.burst_address !== 32'h0) begin miss++; $display("FAIL reset.burst_address got %h want 0", bus.burst_address); end
    vec++; if (bus.burst_wdata !== 64'h0) begin miss++; $display("FAIL reset.burst_wdata got %h want 0", bus.burst_wdata); end
    vec++; if (bus.pmem_rdata !== 256'h0) begin miss++; $display("FAIL reset.pmem_rdata got %h want 0", bus.pmem_rdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    do_read(32'h0000_1234, 32'h0000_1220, LINE_A, "read");
    // line stays in place through idle cycles
    tick(); tick();
    vec++; if (bus.pmem_rdata !== LINE_A) begin miss++;
      $display("FAIL read.idle_hold got %h want %h", bus.pmem_rdata, LINE_A); end
  endtask

  task automatic test_write();
    logic [255:0] l;
    l = LINE_B;
    bus.pmem_write = 1'b1; bus.pmem_address = 32'h8000_00FF; bus.pmem_wdata = LINE_B;
    tick();
    // later changes on the request side must not disturb the transfer
    bus.pmem_write = 1'b0; bus.pmem_wdata = ~LINE_B; bus.pmem_address = 32'h0;
    for (int i = 0; i < 4; i++) begin
      vec++; if (bus.burst_write !== 1'b1) begin miss++;
        $display("FAIL write.burst_write[%0d] got %b want 1", i, bus.burst_write); end
      vec++; if (bus.burst_wdata !== l[i*64 +: 64]) begin miss++;
        $display("FAIL write.wdata[%0d] got %h want %h", i, bus.burst_wdata, l[i*64 +: 64]); end
      vec++; if (bus.burst_address !== 32'h8000_00E0) begin miss++;
        $display("FAIL write.burst_address[%0d] got %h want 800000e0", i, bus.burst_address); end
      bus.burst_resp = 1'b1;
      tick();
    end
    bus.burst_resp = 1'b0;
    vec++; if (bus.pmem_resp !== 1'b1) begin miss++; $display("FAIL write.resp got %b want 1", bus.pmem_resp); end
    vec++; if (bus.burst_write !== 1'b0) begin miss++; $display("FAIL write.burst_write_done got %b want 0", bus.burst_write); end
    vec++; if (bus.burst_wdata !== 64'h0) begin miss++; $display("FAIL write.wdata_done got %h want 0", bus.burst_wdata); end
    tick();
    vec++; if (bus.pmem_resp !== 1'b0) begin miss++; $display("FAIL write.resp_pulse got %b want 0", bus.pmem_resp); end
  endtask

  task automatic test_read_waits();
    logic [6:0] pat;
    logic [255:0] l;
    int b;
    pat = 7'b1011001; // bit k = resp in cycle k: 1,0,0,1,1,0,1
    l = LINE_B;
    b = 0;
    bus.pmem_read = 1'b1; bus.pmem_address = 32'h0000_4040;
    tick();
    bus.pmem_read = 1'b0;
    for (int k = 0; k < 7; k++) begin
      vec++; if (bus.pmem_resp !== 1'b0 || bus.burst_read !== 1'b1) begin miss++;
        $display("FAIL waits.cycle[%0d] resp %b read %b want 0 1", k, bus.pmem_resp, bus.burst_read); end
      bus.burst_resp = pat[k];
      if (pat[k]) begin bus.burst_rdata = l[b*64 +: 64]; b++; end
      else bus.burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      tick();
    end
    bus.burst_resp = 1'b0;
    vec++; if (bus.pmem_resp !== 1'b1) begin miss++; $display("FAIL waits.resp got %b want 1", bus.pmem_resp); end
    vec++; if (bus.pmem_rdata !== LINE_B) begin miss++;
      $display("FAIL waits.rdata got %h want %h", bus.pmem_rdata, LINE_B); end
    tick();
  endtask

  task automatic test_simultaneous();
    bus.pmem_read = 1'b1; bus.pmem_write = 1'b1;
    bus.pmem_address = 32'h0000_0020; bus.pmem_wdata = LINE_B;
    tick();
    for (int i = 0; i < 4; i++) begin
      vec++; if (bus.burst_read !== 1'b1 || bus.burst_write !== 1'b0) begin miss++;
        $display("FAIL simul.beat[%0d] read %b write %b want 1 0", i, bus.burst_read, bus.burst_write); end
      bus.burst_resp = 1'b1; bus.burst_rdata = {32'h5A5A_0000, 32'(i)};
      tick();
    end
    bus.burst_resp = 1'b0;
    vec++; if (bus.pmem_resp !== 1'b1 || bus.burst_write !== 1'b0) begin miss++;
      $display("FAIL simul.done resp %b write %b want 1 0", bus.pmem_resp, bus.burst_write); end
    vec++; if (bus.pmem_rdata !== {64'h5A5A_0000_0000_0003, 64'h5A5A_0000_0000_0002,
                                   64'h5A5A_0000_0000_0001, 64'h5A5A_0000_0000_0000}) begin miss++;
      $display("FAIL simul.rdata got %h", bus.pmem_rdata); end
    bus.pmem_read = 1'b0; bus.pmem_write = 1'b0;
    tick();
    vec++; if (bus.pmem_resp !== 1'b0) begin miss++; $display("FAIL simul.resp_pulse got %b want 0", bus.pmem_resp); end
  endtask

  task automatic test_reset_midwrite();
    bus.pmem_write = 1'b1; bus.pmem_address = 32'h0000_0300; bus.pmem_wdata = LINE_A;
    tick();
    bus.pmem_write = 1'b0;
    bus.burst_resp = 1'b1;
    tick(); tick();
    vec++; if (bus.burst_wdata !== B2) begin miss++;
      $display("FAIL rstmid.wdata2 got %h want %h", bus.burst_wdata, B2); end
    bus.burst_resp = 1'b0; rst = 1'b1;
    tick();
    vec++; if (bus.burst_write !== 1'b0) begin miss++; $display("FAIL rstmid.burst_write got %b want 0", bus.burst_write); end
    vec++; if (bus.burst_wdata !== 64'h0) begin miss++; $display("FAIL rstmid.wdata got %h want 0", bus.burst_wdata); end
    vec++; if (bus.burst_address !== 32'h0) begin miss++; $display("FAIL rstmid.address got %h want 0", bus.burst_address); end
    rst = 1'b0;
    bus.burst_resp = 1'b1; // memory finishing late must not revive the write
    for (int i = 0; i < 4; i++) begin
      tick();
      vec++; if (bus.pmem_resp !== 1'b0 || bus.burst_write !== 1'b0) begin miss++;
        $display("FAIL rstmid.after[%0d] resp %b write %b want 0 0", i, bus.pmem_resp, bus.burst_write); end
    end
    bus.burst_resp = 1'b0;
    do_read(32'h0000_ABCD, 32'h0000_ABC0, LINE_B, "rstmid_read");
  endtask

  task automatic test_spurious_resp();
    bus.burst_resp = 1'b1; bus.burst_rdata = 64'hFFFF_0000_FFFF_0000;
    tick(); tick();
    vec++; if (bus.pmem_resp !== 1'b0 || bus.burst_read !== 1'b0) begin miss++;
      $display("FAIL spur.idle resp %b read %b want 0 0", bus.pmem_resp, bus.burst_read); end
    vec++; if (bus.pmem_rdata !== LINE_B) begin miss++;
      $display("FAIL spur.rdata_hold got %h want %h", bus.pmem_rdata, LINE_B); end
    bus.burst_resp = 1'b0;
    tick();
    do_read(32'hFFFF_FFFF, 32'hFFFF_FFE0, LINE_A, "spur_read");
    vec++; if (bus.pmem_rdata[63:0] !== B0) begin miss++;
      $display("FAIL spur.beat0 got %h want %h", bus.pmem_rdata[63:0], B0); end
  endtask

  initial begin
    bus.pmem_address = '0; bus.pmem_read = 1'b0; bus.pmem_write = 1'b0;
    bus.pmem_wdata = '0; bus.burst_rdata = '0; bus.burst_resp = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_read_waits();
    test_simultaneous();
    test_reset_midwrite();
    test_spurious_resp();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

endmodule
